// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient load states and
// memory sizing helpers used by datapath and responder.
package fir_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } load_state_t;

  function automatic int sampleDepth(input int n);
    return n - 1;
  endfunction

  function automatic int coeffCount(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/fir_coef_loader.sv
// Coefficient load state machine: accepts host beats,
// fills the coefficient store and flags malformed loads.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int CoeffWidth = 12,
  parameter int CoeffCount = 5
) (
  input  logic clk,
  input  logic resetN,
  input  logic valid,
  input  logic [CoeffWidth-1:0] data,
  input  logic last,
  output logic [CoeffCount-1:0][CoeffWidth-1:0] entries,
  output load_state_t state,
  output logic loadErr
);

  localparam int CntW = $clog2(CoeffCount + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CoeffCount);

  logic [CntW-1:0] count;
  logic [CntW-1:0] idx;
  logic [CntW-1:0] nxt;
  logic restart;
  logic full;

  // EMPTY and READY both start a fresh load at entry 0
  assign restart = (state != LOADING);
  assign idx = restart ? '0 : count;
  assign full = !restart && (count == CntMax);
  assign nxt = idx + 1'b1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= EMPTY;
      count   <= '0;
      entries <= '0;
      loadErr <= 1'b0;
    end else if (valid) begin
      if (full) begin
        state   <= EMPTY;
        count   <= '0;
        loadErr <= 1'b1;
      end else begin
        entries[idx] <= data;
        if (last) begin
          count <= '0;
          if (nxt == CntMax) begin
            state <= READY;
          end else begin
            state   <= EMPTY;
            loadErr <= 1'b1;
          end
        end else begin
          state <= LOADING;
          count <= nxt;
        end
      end
    end
  end

endmodule

// File: rtl/fir_mem_responder.sv
// Sample RAM and coefficient store behind the FIR datapath.
// FIR_MEM_CHECK_EN enables the addrErr/collErr checkers.
module fir_mem_responder
  import fir_pkg::*;
#(
  parameter int NrOfTaps        = 10,
  parameter int SampleWidth     = 8,
  parameter int CoeffWidth      = 12,
  parameter int AddrsWidth      = 4,
  parameter int CoeffAddrsWidth = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic rwN1,
  input  logic rwN2,
  input  logic [AddrsWidth-1:0] sampleAddrs1,
  input  logic [AddrsWidth-1:0] sampleAddrs2,
  input  logic [SampleWidth-1:0] dataIn,
  output logic [SampleWidth-1:0] dataOut1,
  output logic [SampleWidth-1:0] dataOut2,
  input  logic read,
  input  logic [CoeffAddrsWidth-1:0] coeffAddrs,
  output logic [CoeffWidth-1:0] coeff,
  input  logic coefLoadValid,
  output logic coefLoadReady,
  input  logic [CoeffWidth-1:0] coefLoadData,
  input  logic coefLoadLast,
  output logic coeffValid,
  output logic loadErr,
  output logic addrErr,
  output logic collErr
);

  localparam int Depth = sampleDepth(NrOfTaps);
  localparam int CoeffCount = coeffCount(NrOfTaps);
  localparam logic [AddrsWidth-1:0] MaxAddr =
    AddrsWidth'(Depth - 1);
  localparam logic [CoeffAddrsWidth:0] CoefLim =
    (CoeffAddrsWidth + 1)'(CoeffCount);

  logic [SampleWidth-1:0] mem [Depth];
  logic [CoeffCount-1:0][CoeffWidth-1:0] entries;
  load_state_t state;
  logic in1, in2, cIn, ready;
  logic [CoeffWidth-1:0] coeffRd;
  logic [CoeffWidth-1:0] hold;

  assign in1 = (sampleAddrs1 <= MaxAddr);
  assign in2 = (sampleAddrs2 <= MaxAddr);
  assign cIn = ({1'b0, coeffAddrs} < CoefLim);
  assign ready = (state == READY);

  assign dataOut1 = in1 ? mem[sampleAddrs1] : '0;
  assign dataOut2 = in2 ? mem[sampleAddrs2] : '0;

  // port 1 is written last so it wins a same-address clash
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (!rwN2 && in2) mem[sampleAddrs2] <= dataIn;
      if (!rwN1 && in1) mem[sampleAddrs1] <= dataIn;
    end
  end

  fir_coef_loader #(
    .CoeffWidth(CoeffWidth),
    .CoeffCount(CoeffCount)
  ) u_loader (
    .clk(clk),
    .resetN(resetN),
    .valid(coefLoadValid),
    .data(coefLoadData),
    .last(coefLoadLast),
    .entries(entries),
    .state(state),
    .loadErr(loadErr)
  );

  assign coefLoadReady = 1'b1;
  assign coeffValid = ready;

  assign coeffRd = (ready && cIn) ? entries[coeffAddrs] : '0;
  assign coeff = read ? coeffRd : hold;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) hold <= '0;
    else if (read) hold <= coeffRd;
  end

`ifdef FIR_MEM_CHECK_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addrErr <= 1'b0;
      collErr <= 1'b0;
    end else begin
      if (!in1 || !in2 || (read && !cIn))
        addrErr <= 1'b1;
      if ((!rwN1 && !rwN2 &&
           sampleAddrs1 == sampleAddrs2) ||
          (read && !ready))
        collErr <= 1'b1;
    end
  end
`else
  assign addrErr = 1'b0;
  assign collErr = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mem_responder.sv
// Directed bench for fir_mem_responder with a queue-based
// reference model compared on every falling edge.
module tb_fir_mem_responder;

`ifdef FIR_MEM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int DEPTH = 9;
  localparam int CC = 5;

  logic clk = 1'b0;
  logic resetN;
  logic rwN1, rwN2;
  logic [3:0] sampleAddrs1, sampleAddrs2;
  logic [7:0] dataIn, dataOut1, dataOut2;
  logic read;
  logic [2:0] coeffAddrs;
  logic [11:0] coeff;
  logic coefLoadValid, coefLoadReady;
  logic [11:0] coefLoadData;
  logic coefLoadLast;
  logic coeffValid, loadErr, addrErr, collErr;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] ms [0:15];
  logic [11:0] mc [0:7];
  logic [11:0] q [$];
  logic [11:0] mhold;
  logic mvalid, mlerr, maerr, mcerr;

  always #5 clk = ~clk;

  fir_mem_responder dut (
    .clk(clk),
    .resetN(resetN),
    .rwN1(rwN1),
    .rwN2(rwN2),
    .sampleAddrs1(sampleAddrs1),
    .sampleAddrs2(sampleAddrs2),
    .dataIn(dataIn),
    .dataOut1(dataOut1),
    .dataOut2(dataOut2),
    .read(read),
    .coeffAddrs(coeffAddrs),
    .coeff(coeff),
    .coefLoadValid(coefLoadValid),
    .coefLoadReady(coefLoadReady),
    .coefLoadData(coefLoadData),
    .coefLoadLast(coefLoadLast),
    .coeffValid(coeffValid),
    .loadErr(loadErr),
    .addrErr(addrErr),
    .collErr(collErr)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_d(input logic [3:0] a);
    return (a < DEPTH) ? ms[a] : 8'h00;
  endfunction

  function automatic logic [11:0] exp_coeff();
    if (!read) return mhold;
    if (mvalid && coeffAddrs < CC) return mc[coeffAddrs];
    return 12'h000;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 16; i++) ms[i] = 8'h00;
    for (int i = 0; i < 8; i++) mc[i] = 12'h000;
    q.delete();
    mhold = 12'h000;
    mvalid = 1'b0;
    mlerr = 1'b0;
    maerr = 1'b0;
    mcerr = 1'b0;
  endtask

  // Reference model of one clock edge, from pre-edge inputs
  task automatic model_edge();
    if (!resetN) return;
    if (read) mhold = exp_coeff();
    if (CHK) begin
      if (sampleAddrs1 >= DEPTH || sampleAddrs2 >= DEPTH)
        maerr = 1'b1;
      if (read && coeffAddrs >= CC) maerr = 1'b1;
      if (!rwN1 && !rwN2 && sampleAddrs1 == sampleAddrs2)
        mcerr = 1'b1;
      if (read && !mvalid) mcerr = 1'b1;
    end
    if (!rwN2 && sampleAddrs2 < DEPTH) ms[sampleAddrs2] = dataIn;
    if (!rwN1 && sampleAddrs1 < DEPTH) ms[sampleAddrs1] = dataIn;
    if (coefLoadValid) begin
      if (mvalid) begin
        mvalid = 1'b0;
        q.delete();
      end
      q.push_back(coefLoadData);
      if (q.size() > CC) begin
        mlerr = 1'b1;
        q.delete();
      end else if (coefLoadLast) begin
        if (q.size() == CC) begin
          foreach (q[i]) mc[i] = q[i];
          mvalid = 1'b1;
        end else begin
          mlerr = 1'b1;
        end
        q.delete();
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    chk("dataOut1", dataOut1, exp_d(sampleAddrs1));
    chk("dataOut2", dataOut2, exp_d(sampleAddrs2));
    chk("coeff", coeff, exp_coeff());
    chk("coeffValid", coeffValid, mvalid);
    chk("coefLoadReady", coefLoadReady, 1'b1);
    chk("loadErr", loadErr, mlerr);
    chk("addrErr", addrErr, maerr);
    chk("collErr", collErr, mcerr);
  end

  task automatic do_reset();
    resetN = 1'b0;
    mreset();
    step();
    step();
    resetN = 1'b1;
    step();
  endtask

  task automatic beat(input logic [11:0] d, input logic l);
    coefLoadValid = 1'b1;
    coefLoadData = d;
    coefLoadLast = l;
    step();
    coefLoadValid = 1'b0;
    coefLoadLast = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    rwN1 = 1'b1;
    rwN2 = 1'b1;
    sampleAddrs1 = 4'd0;
    sampleAddrs2 = 4'd0;
    dataIn = 8'h00;
    read = 1'b0;
    coeffAddrs = 3'd0;
    coefLoadValid = 1'b0;
    coefLoadData = 12'h000;
    coefLoadLast = 1'b0;
    mreset();
    do_reset();
    step();
    chk("rst_coeffValid", coeffValid, 1'b0);
    chk("rst_coeff", coeff, 12'h000);
    chk("rst_ready", coefLoadReady, 1'b1);
    chk("rst_loadErr", loadErr, 1'b0);
    chk("rst_dataOut1", dataOut1, 8'h00);

    // Complete 5-beat load
    beat(12'h010, 1'b0);
    beat(12'h020, 1'b0);
    beat(12'h040, 1'b0);
    beat(12'h080, 1'b0);
    beat(12'h100, 1'b1);
    chk("load5_valid", coeffValid, 1'b1);
    chk("load5_model_valid", mvalid, 1'b1);
    read = 1'b1;
    coeffAddrs = 3'd3;
    #1;
    chk("load5_coeff3", coeff, 12'h080);
    chk("load5_model_coeff3", exp_coeff(), 12'h080);
    step();
    read = 1'b0;
    coeffAddrs = 3'd1;
    #1;
    chk("hold_coeff", coeff, 12'h080);

    // Short load
    beat(12'h111, 1'b0);
    beat(12'h222, 1'b0);
    beat(12'h333, 1'b1);
    chk("short_loadErr", loadErr, 1'b1);
    chk("short_valid", coeffValid, 1'b0);
    read = 1'b1;
    coeffAddrs = 3'd0;
    #1;
    chk("short_coeff", coeff, 12'h000);
    step();
    chk("short_collErr", collErr, CHK);
    read = 1'b0;

    // Read-during-write returns old data
    do_reset();
    rwN1 = 1'b0;
    sampleAddrs1 = 4'd8;
    sampleAddrs2 = 4'd8;
    dataIn = 8'h5A;
    #1;
    chk("rdw_old", dataOut2, 8'h00);
    step();
    rwN1 = 1'b1;
    #1;
    chk("rdw_new", dataOut2, 8'h5A);

    // Dual write to one address
    rwN1 = 1'b0;
    rwN2 = 1'b0;
    sampleAddrs1 = 4'd3;
    sampleAddrs2 = 4'd3;
    dataIn = 8'h77;
    step();
    rwN1 = 1'b1;
    rwN2 = 1'b1;
    #1;
    chk("dual_mem3", dataOut1, 8'h77);
    chk("dual_collErr", collErr, CHK);
    chk("dual_addrErr", addrErr, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      rwN2 = 1'b0;
      sampleAddrs2 = 4'(i);
      dataIn = 8'(i * 13 + 1);
      step();
    end
    rwN2 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sampleAddrs1 = 4'(i);
      sampleAddrs2 = 4'(DEPTH - 1 - i);
      step();
    end

    // Out-of-range read and dropped write
    sampleAddrs2 = 4'd9;
    #1;
    chk("oor_dataOut2", dataOut2, 8'h00);
    step();
    chk("oor_addrErr", addrErr, CHK);
    sampleAddrs2 = 4'd0;
    rwN1 = 1'b0;
    sampleAddrs1 = 4'd12;
    dataIn = 8'hEE;
    step();
    rwN1 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sampleAddrs1 = 4'(i);
      step();
    end

    // Reset during the third beat
    do_reset();
    sampleAddrs1 = 4'd0;
    beat(12'hAAA, 1'b0);
    beat(12'hBBB, 1'b0);
    coefLoadValid = 1'b1;
    coefLoadData = 12'hCCC;
    resetN = 1'b0;
    mreset();
    #1;
    chk("midrst_valid", coeffValid, 1'b0);
    chk("midrst_loadErr", loadErr, 1'b0);
    chk("midrst_addrErr", addrErr, 1'b0);
    chk("midrst_collErr", collErr, 1'b0);
    chk("midrst_coeff", coeff, 12'h000);
    step();
    coefLoadValid = 1'b0;
    step();
    resetN = 1'b1;
    step();
    beat(12'h00A, 1'b0);
    beat(12'h0B0, 1'b0);
    beat(12'hC00, 1'b0);
    beat(12'h123, 1'b0);
    beat(12'hFED, 1'b1);
    chk("reload_valid", coeffValid, 1'b1);
    read = 1'b1;
    coeffAddrs = 3'd4;
    #1;
    chk("reload_coeff4", coeff, 12'hFED);
    for (int i = 0; i < 8; i++) begin
      coeffAddrs = 3'(i);
      step();
    end
    read = 1'b0;
    step();

    // Overrun: sixth beat without Last
    do_reset();
    for (int i = 0; i < CC + 1; i++)
      beat(12'(i + 1), 1'b0);
    chk("overrun_loadErr", loadErr, 1'b1);
    chk("overrun_valid", coeffValid, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fir_mem_responder.md
# fir_mem_responder

Memory responder on the far side of the FIR datapath's RAM and ROM interfaces. It owns the two-port circular sample buffer and a loadable coefficient store. It answers the FIR's address, read/write and read strobes with zero-latency read data. Coefficients are loaded at run time through a valid/ready stream from the host side.

## Interface
Parameters:
- NrOfTaps, 10, filter length; sample buffer depth = NrOfTaps-1 (addresses 0..NrOfTaps-2).
- SampleWidth, 8, sample width.
- CoeffWidth, 12, coefficient width.
- AddrsWidth, 4, sample address width.
- CoeffAddrsWidth, 3, coefficient address width.
- CoeffCount = (NrOfTaps+1)/2, derived: number of coefficients in a complete load (5 at default).

Ports:
- Reset and clock: reset resetN, asynchronous, active-low; clock clk.
- rwN1  in  1  port 1 read/write-not; 0 writes dataIn at sampleAddrs1.
- rwN2  in  1  port 2 read/write-not; 0 writes dataIn at sampleAddrs2.
- sampleAddrs1, sampleAddrs2  in  AddrsWidth  sample addresses.
- dataIn  in  SampleWidth  write data, shared by both ports.
- dataOut1, dataOut2  out  SampleWidth  read data.
- read  in  1  coefficient read enable.
- coeffAddrs  in  CoeffAddrsWidth  coefficient address.
- coeff  out  CoeffWidth  coefficient data.
- coefLoadValid  in  1  load beat valid.
- coefLoadReady  out  1  load beat accepted.
- coefLoadData  in  CoeffWidth  load beat data.
- coefLoadLast  in  1  final beat of a load.
- coeffValid  out  1  coefficient set complete and usable.
- loadErr, addrErr, collErr  out  1 each  sticky error flags.

## Operation
- Sample RAM:
  - Reads are combinational. dataOutN = mem[sampleAddrsN] if the address is ≤ NrOfTaps-2, else 0.
  - Writes take effect at the clk edge where rwNN=0.
  - A read of an address written in the same cycle returns the old contents.
  - If both ports write the same address, port 1 wins.
  - A write to an out-of-range address is dropped.
- Coefficient store has CoeffCount entries. Load state machine:
  - EMPTY (reset state):
    - coeffValid=0.
    - The first accepted beat writes entry 0 and goes to LOADING with count=1.
    - If that first beat also has coefLoadLast=1, the state machine evaluates the end of load immediately (see below).
  - LOADING:
    - Each accepted beat writes entry[count] and increments count.
    - A beat with coefLoadLast=1 ends the load. If the final count equals CoeffCount, go to READY. Otherwise set loadErr and go to EMPTY.
    - A beat arriving when count==CoeffCount without Last is dropped; loadErr is set and the state goes to EMPTY.
  - READY:
    - coeffValid=1.
    - An accepted beat restarts the load at entry 0 (LOADING) and clears coeffValid in the same edge.
  - coefLoadReady=1 in all states. A beat transfers when valid && ready.
- Coefficient read:
  - When read=1, coeff = entry[coeffAddrs] if the state is READY and coeffAddrs < CoeffCount; otherwise coeff = 0.
  - When read=0, coeff holds the last driven value (registered hold).
- Error flags are sticky until reset:
  - loadErr is always active.
  - addrErr: an out-of-range sample address with any port active, or read=1 with coeffAddrs ≥ CoeffCount.
  - collErr: dual write to the same address, or read=1 while not READY.

## Timing
- Sample read latency is 0: data is valid in the same cycle the address is presented, so the FIR can sample it on the next edge.
- Write latency is 1 edge.
- Coefficient read is combinational while read=1; the hold register updates every edge that read=1.
- coeffValid rises on the edge that accepts the correct Last beat and falls on the edge that accepts a restarting beat.
- Reset values:
  - All sample and coefficient entries 0.
  - State EMPTY, count 0.
  - coeffValid=0, hold register 0; coeff=0, dataOut1/2=0 (in-range address of zeroed RAM).
  - coefLoadReady=1.
  - All error flags 0.
- Reset asserted mid-load aborts the load; the state returns to EMPTY and the entries are zeroed.

## Configuration
- FIR_MEM_CHECK_EN defined: addrErr and collErr are implemented as described.
- FIR_MEM_CHECK_EN undefined: addrErr and collErr are tied to 0 and their logic is removed.
- In both cases, out-of-range reads return 0, out-of-range writes are dropped, and loadErr stays active.

## Structure
- Package fir_pkg holds:
  - the load-state enum (EMPTY, LOADING, READY);
  - the functions sampleDepth(NrOfTaps) and coeffCount(NrOfTaps).
  - The FIR datapath shares this package.
- One sub-module, fir_coef_loader, contains the load state machine, count, entry writes and loadErr. The top level holds the sample RAM, the read muxes and the check logic.

## Test plan
- Load 5 beats 0x010,0x020,0x040,0x080,0x100 (Last on 5th) -> coeffValid=1 the next cycle; read=1, coeffAddrs=3 -> coeff=0x080.
- Load 3 beats with Last on 3rd -> loadErr=1, coeffValid=0; read=1, coeffAddrs=0 -> coeff=0 (and collErr=1 with FIR_MEM_CHECK_EN).
- Write 0x5A at addr 8 (rwN1=0) while port 2 reads addr 8 -> dataOut2 shows old 0x00 that cycle and 0x5A the next.
- Both ports write addr 3 with dataIn=0x77 -> mem[3]=0x77; collErr=1 only with FIR_MEM_CHECK_EN.
- sampleAddrs2=9 with rwN2=1 -> dataOut2=0; addrErr=1 with the macro, 0 without.
- Assert resetN low during the 3rd load beat -> coeffValid=0, all flags 0, coeff=0; a following 5-beat load succeeds.
